// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU) returning {remainder, quotient}.
// Optional macro DIV_BYZERO_FAST_EN: one-cycle divide-by-zero path plus div_zero_o flag.
module div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     dividend_i,
    input  logic [DATA_W-1:0]     divisor_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
`ifdef DIV_BYZERO_FAST_EN
    output logic                  div_zero_o,
`endif
    output logic                  busy_o
);

    typedef enum logic [1:0] {FREE, ON, BYZERO, END} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_W-1:0]       rem, quo, dvsr;
    logic                    neg_q, neg_r;
    logic [DATA_W:0]         trial;
    logic [DATA_W-1:0]       rem_nx, quo_nx;
    logic signed [DATA_W-1:0] dividend_s, divisor_s;
    logic                    accept;

    // Two's complement negate when neg is set; wraps mod 2**DATA_W.
    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                     input logic neg);
        return neg ? (~v + DATA_W'(1)) : v;
    endfunction

    assign dividend_s = $signed(dividend_i);
    assign divisor_s  = $signed(divisor_i);
    assign accept     = (state == FREE) && start_i && !annul_i;

    // One restoring step: shift {rem,quo} left, subtract divisor if it fits.
    always_comb begin
        trial  = {rem, quo[DATA_W-1]} - {1'b0, dvsr};
        rem_nx = {rem[DATA_W-2:0], quo[DATA_W-1]};
        quo_nx = {quo[DATA_W-2:0], 1'b0};
        if (!trial[DATA_W]) begin
            rem_nx = trial[DATA_W-1:0];
            quo_nx = {quo[DATA_W-2:0], 1'b1};
        end
    end

    // Datapath registers carry no reset; they are always reloaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem   <= '0;
            quo   <= (divisor_i == '0) ? dividend_i
                                       : apply_sign(dividend_i, signed_i && (dividend_s < 0));
            dvsr  <= apply_sign(divisor_i, signed_i && (divisor_s < 0));
            neg_q <= signed_i && ((dividend_s < 0) != (divisor_s < 0));
            neg_r <= signed_i && (dividend_s < 0);
        end else if (state == ON) begin
            rem <= rem_nx;
            quo <= quo_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
`ifdef DIV_BYZERO_FAST_EN
            div_zero_o <= 1'b0;
`endif
        end else begin
            ready_o <= 1'b0;
`ifdef DIV_BYZERO_FAST_EN
            div_zero_o <= 1'b0;
`endif
            case (state)
                FREE: begin
                    if (accept) begin
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= (divisor_i == '0) ? BYZERO : ON;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        state  <= FREE;
                        busy_o <= 1'b0;
                    end else if (cnt == LAST) begin
                        state    <= END;
                        ready_o  <= 1'b1;
                        result_o <= {apply_sign(rem_nx, neg_r), apply_sign(quo_nx, neg_q)};
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        state  <= FREE;
                        busy_o <= 1'b0;
`ifdef DIV_BYZERO_FAST_EN
                    end else begin
                        state      <= END;
                        ready_o    <= 1'b1;
                        div_zero_o <= 1'b1;
                        result_o   <= {quo, {DATA_W{1'b1}}};
                    end
`else
                    end else if (cnt == LAST) begin
                        state    <= END;
                        ready_o  <= 1'b1;
                        result_o <= {quo, {DATA_W{1'b1}}};
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                END: begin
                    state  <= FREE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= FREE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
